sim_config_s6: RTL and testbench

// - Behavioural model of the Spartan-6 configuration engine on a 16-bit slave SelectMAP port.
// - Sits under the ICAP wrapper; the wrapper feeds it an init bitstream, then hands the port to user logic.
// - Handles sync detection, type1/type2 packets, register writes and reads, START/DESYNC, and DONE/BUSY.

---
 rtl/sim_config_s6_if.sv | 14 +
 rtl/sim_config_s6.sv | 147 ++++++++++++++
 tb/tb_sim_config_s6.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sim_config_s6_if.sv
// sim_config_s6_if: SelectMAP control/status bundle between host and configuration engine
// Host drives PROGB, INITB, M, CSIB, RDWRB; engine returns BUSY, DONE, CSOB.
interface sim_config_s6_if;
    logic       PROGB;
    logic       INITB;
    logic [1:0] M;
    logic       CSIB;
    logic       RDWRB;
    logic       BUSY;
    logic       DONE;
    logic       CSOB;
    modport master (output PROGB, INITB, M, CSIB, RDWRB, input BUSY, DONE, CSOB);
    modport slave  (input PROGB, INITB, M, CSIB, RDWRB, output BUSY, DONE, CSOB);
endinterface

// File: rtl/sim_config_s6.sv
// sim_config_s6: behavioural Spartan-6 configuration engine on a 16-bit slave SelectMAP port
// Ports: CCLK clock; RST sync active-high reset; cfg_bus control/status (PROGB, INITB, M,
//        CSIB, RDWRB in; BUSY, DONE, CSOB out); D bidirectional data, bit-reversed per byte.
module sim_config_s6 #(
    parameter logic [31:0] DEVICE_ID    = 32'h04000093,
    parameter string       ICAP_SUPPORT = "FALSE"
) (
    input  logic           CCLK,
    input  logic           RST,
    sim_config_s6_if.slave cfg_bus,
    inout  wire [15:0]     D
);
    typedef enum logic [3:0] {
        S_CLEAR, S_WINIT, S_UNSYNC, S_HDR, S_WC_HI, S_WC_LO, S_WDATA, S_RWAIT, S_RDATA
    } state_t;
    // registers that hold written values: CRC, FAR_MAJ, FAR_MIN, CMD, CTL, MASK, COR1, COR2
    localparam logic [15:0] WR_MASK = 16'h0CE7;
    state_t      state, nxt;
    logic [5:0]  addr;
    logic [1:0]  op;
    logic [31:0] rem;
    logic [11:0] id_hi;
    logic [2:0]  su_cnt;
    logic        ph, seen, done, id_err, csob_q;
    logic [15:0] regs [16];
    logic        active, clr, rd, acc, busy, sync, last;
    logic [15:0] w, rd_word;

    function automatic logic [15:0] brev(input logic [15:0] x);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i]     = x[7 - i];
            r[8 + i] = x[15 - i];
        end
        return r;
    endfunction

    assign active  = ICAP_SUPPORT == "TRUE" || cfg_bus.M == 2'b10;
    assign clr     = RST || !cfg_bus.PROGB;
    assign rd      = active && !cfg_bus.CSIB && cfg_bus.RDWRB;
    assign sync    = state inside {S_HDR, S_WC_HI, S_WC_LO, S_WDATA, S_RWAIT, S_RDATA};
    // BUSY covers the first read cycle (RWAIT) and any cycle a pending read is not being clocked out
    assign busy    = state inside {S_CLEAR, S_WINIT, S_RWAIT} || (state == S_RDATA && !rd);
    assign acc     = active && !cfg_bus.CSIB && !cfg_bus.RDWRB && !busy;
    assign w       = brev(D);
    assign last    = rem == 32'd1;
    // ph alternates per payload word, selecting the IDCODE half
    assign rd_word = addr == 6'h0E ? (ph ? DEVICE_ID[15:0] : DEVICE_ID[31:16]) :
                     addr == 6'h08 ? {1'b0, id_err, done, cfg_bus.INITB, 8'h00, sync, 3'b000} :
                     addr[5:4] == 2'b00 && WR_MASK[addr[3:0]] ? regs[addr[3:0]] : 16'h0000;
    assign D            = state == S_RDATA && rd ? brev(rd_word) : 16'hzzzz;
    assign cfg_bus.BUSY = busy;
    assign cfg_bus.DONE = done;
    assign cfg_bus.CSOB = done ? csob_q : 1'b1;

    always_ff @(posedge CCLK) begin
        if (RST)
            state <= S_CLEAR;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (clr)
            nxt = S_CLEAR;
        else
            unique case (state)
                S_CLEAR:  nxt = S_WINIT;
                S_WINIT:  nxt = cfg_bus.INITB ? S_UNSYNC : S_WINIT;
                S_UNSYNC: nxt = acc && seen && w == 16'h5566 ? S_HDR : S_UNSYNC;
                S_HDR:
                    if (acc && w[15:13] == 3'b001 && ^w[12:11] && w[4:0] != 5'd0)
                        nxt = w[12] ? S_WDATA : S_RWAIT;
                    else if (acc && w[15:13] == 3'b010)
                        nxt = S_WC_HI;
                S_WC_HI:  nxt = acc ? S_WC_LO : S_WC_HI;
                S_WC_LO:
                    if (acc)
                        nxt = {rem[31:16], w} == 32'd0 || !(^op) ? S_HDR : op[1] ? S_WDATA : S_RWAIT;
                S_WDATA:
                    if (acc)
                        nxt = addr == 6'h05 && w[4:0] == 5'h0D ? S_UNSYNC : last ? S_HDR : S_WDATA;
                S_RWAIT:  nxt = rd ? S_RDATA : S_RWAIT;
                S_RDATA:  nxt = !rd || last ? S_HDR : S_RDATA;
                default:  nxt = S_CLEAR;
            endcase
    end

    always_ff @(posedge CCLK) begin
        if (clr) begin
            addr   <= '0;
            op     <= '0;
            rem    <= '0;
            id_hi  <= '0;
            su_cnt <= '0;
            ph     <= 1'b0;
            seen   <= 1'b0;
            done   <= 1'b0;
            id_err <= 1'b0;
            csob_q <= 1'b1;
            for (int i = 0; i < 16; i++)
                regs[i] <= '0;
        end else begin
            csob_q <= cfg_bus.CSIB;
            // startup sequencer: DONE lands on the 4th edge after START is accepted
            if (su_cnt != 3'd0) begin
                su_cnt <= su_cnt - 3'd1;
                if (su_cnt == 3'd1)
                    done <= 1'b1;
            end
            if (state == S_UNSYNC && acc)
                seen <= w == 16'hAA99;
            if (state == S_HDR && acc) begin
                ph <= 1'b0;
                if (w[15:13] == 3'b001) begin
                    addr <= w[10:5];
                    op   <= w[12:11];
                    rem  <= {27'd0, w[4:0]};
                end else if (w[15:13] == 3'b010)
                    op <= w[12:11];
            end
            if (state == S_WC_HI && acc)
                rem[31:16] <= w;
            if (state == S_WC_LO && acc)
                rem[15:0] <= w;
            if (state == S_WDATA && acc) begin
                rem <= rem - 32'd1;
                ph  <= !ph;
                if (addr[5:4] == 2'b00 && WR_MASK[addr[3:0]])
                    regs[addr[3:0]] <= w;
                if (addr == 6'h0E && !ph)
                    id_hi <= w[11:0];
                if (addr == 6'h0E && ph && {id_hi, w} != DEVICE_ID[27:0])
                    id_err <= 1'b1;
                if (addr == 6'h05 && w[4:0] == 5'h05)
                    su_cnt <= 3'd4;
                if (addr == 6'h05 && w[4:0] == 5'h07)
                    regs[0] <= '0;
            end
            if (state == S_RDATA && rd) begin
                rem <= rem - 32'd1;
                ph  <= !ph;
            end
        end
    end
endmodule

// File: tb/tb_sim_config_s6.sv
// tb_sim_config_s6: self-checking bench for sim_config_s6 (vector table, hand sequences, random register traffic vs model)
module tb_sim_config_s6;
    localparam logic [31:0] ID = 32'h04000093;
    logic        CCLK  = 1'b0;
    logic        RST   = 1'b1;
    logic [15:0] d_drv = 16'h0000;
    logic        d_oe  = 1'b0;
    wire  [15:0] D;
    int          errs   = 0;
    int          checks = 0;
    logic [15:0] model_reg [64];

    typedef struct {
        logic        csib;
        logic [15:0] d;
        logic        busy;
        logic        done;
    } vec_t;
    vec_t tbl [14];

    sim_config_s6_if bus ();
    sim_config_s6 #(.DEVICE_ID(ID), .ICAP_SUPPORT("FALSE")) dut (
        .CCLK(CCLK), .RST(RST), .cfg_bus(bus), .D(D)
    );

    assign D = d_oe ? d_drv : 16'hzzzz;
    always #5 CCLK = ~CCLK;

    function automatic logic [15:0] brev(input logic [15:0] x);
        logic [15:0] r;
        for (int i = 0; i < 16; i++)
            r[i] = x[(i & 8) | (7 - (i & 7))];
        return r;
    endfunction

    function automatic logic [15:0] hdr(input logic [1:0] o, input logic [5:0] a, input logic [4:0] n);
        return {3'b001, o, a, n};
    endfunction

    function automatic logic [15:0] stat_word(input logic ie, input logic dn);
        return {1'b0, ie, dn, 1'b1, 8'h00, 1'b1, 3'b000};
    endfunction

    function automatic bit writable(input logic [5:0] a);
        return a inside {6'h00, 6'h01, 6'h02, 6'h05, 6'h06, 6'h07, 6'h0A, 6'h0B};
    endfunction

    task automatic mwrite(input logic [5:0] a, input logic [15:0] v);
        if (writable(a))
            model_reg[a] = v;
        if (a == 6'h05 && v[4:0] == 5'h07)
            model_reg[0] = 16'h0000;
    endtask

    task automatic tick;
        @(posedge CCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.CSIB = 1'b1;
        bus.RDWRB = 1'b0;
        d_oe = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wr_raw(input logic [15:0] d);
        bus.CSIB = 1'b0;
        bus.RDWRB = 1'b0;
        d_oe = 1'b1;
        d_drv = d;
        tick();
    endtask

    task automatic wr(input logic [15:0] w);
        wr_raw(brev(w));
    endtask

    task automatic wreg(input logic [5:0] a, input logic [15:0] v);
        wr(hdr(2'b10, a, 5'd1));
        wr(v);
        mwrite(a, v);
    endtask

    task automatic rd(input string name, input logic [5:0] a, input logic [15:0] e0,
                      input logic [15:0] e1, input int n);
        wr(hdr(2'b01, a, 5'(n)));
        bus.RDWRB = 1'b1;
        d_oe = 1'b0;
        #1;
        chk({name, " first-cycle busy"}, bus.BUSY, 1);
        tick();
        for (int i = 0; i < n; i++) begin
            chk({name, " busy"}, bus.BUSY, 0);
            chk($sformatf("%s data%0d", name, i), D, brev(i == 0 ? e0 : e1));
            tick();
        end
        bus.CSIB = 1'b1;
        bus.RDWRB = 1'b0;
    endtask

    task automatic run_tbl(input bit swap);
        logic [15:0] d;
        for (int i = 0; i < 14; i++) begin
            d = tbl[i].d;
            if (swap && d == 16'h5599)
                d = 16'hAA66;
            else if (swap && d == 16'hAA66)
                d = 16'h5599;
            if (tbl[i].csib)
                idle(1);
            else
                wr_raw(d);
            chk($sformatf("tbl%0d%s busy", i, swap ? "_swap" : ""), bus.BUSY, tbl[i].busy);
            chk($sformatf("tbl%0d%s done", i, swap ? "_swap" : ""), bus.DONE, tbl[i].done && !swap);
            chk($sformatf("tbl%0d%s csob", i, swap ? "_swap" : ""), bus.CSOB, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

    initial begin
        logic [5:0]  addrs [14];
        logic [5:0]  a;
        logic [15:0] v;
        int          n;
        addrs = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0A, 6'h0B,
                  6'h09, 6'h0C, 6'h0D, 6'h15, 6'h1F};
        foreach (model_reg[i])
            model_reg[i] = 16'h0000;
        for (int i = 0; i < 14; i++)
            tbl[i] = '{1'b0, 16'hFFFF, 1'b0, 1'b0};
        tbl[4].d  = 16'h5599;
        tbl[5].d  = 16'hAA66;
        tbl[8].d  = 16'h0C85;
        tbl[9].d  = 16'h00A0;
        for (int i = 10; i < 14; i++)
            tbl[i].csib = 1'b1;
        tbl[13].done = 1'b1;

        bus.PROGB = 1'b1;
        bus.INITB = 1'b0;
        bus.M     = 2'b10;
        bus.CSIB  = 1'b1;
        bus.RDWRB = 1'b0;
        RST = 1'b1;
        repeat (2) tick();
        chk("reset busy", bus.BUSY, 1);
        chk("reset done", bus.DONE, 0);
        chk("reset csob", bus.CSOB, 1);
        RST = 1'b0;
        repeat (3) tick();
        chk("wait_init busy", bus.BUSY, 1);
        chk("wait_init done", bus.DONE, 0);
        bus.INITB = 1'b1;
        tick();
        chk("initb busy", bus.BUSY, 0);

        run_tbl(1'b1);
        run_tbl(1'b0);
        mwrite(6'h05, 16'h0005);

        wr(16'h2000);
        chk("csob follows csib low", bus.CSOB, 0);
        idle(1);
        chk("csob follows csib high", bus.CSOB, 1);

        rd("idcode", 6'h0E, ID[31:16], ID[15:0], 2);
        rd("stat", 6'h08, stat_word(1'b0, 1'b1), 16'h0000, 1);

        for (int t = 0; t < 40; t++) begin
            a = addrs[$urandom_range(0, 13)];
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(1, 3);
                wr(hdr(2'b10, a, 5'(n)));
                for (int j = 0; j < n; j++) begin
                    v = 16'($urandom);
                    if ($urandom_range(0, 2) == 0)
                        idle(1);
                    wr(v);
                    mwrite(a, v);
                end
            end else begin
                n = $urandom_range(1, 2);
                rd($sformatf("rnd%0d_a%02h", t, a), a, model_reg[a], model_reg[a], n);
            end
            if ($urandom_range(0, 3) == 0)
                wr(16'h2000);
        end

        wr(hdr(2'b10, 6'h06, 5'd0));
        wr(16'h5000);
        wr(16'h0000);
        wr(16'h0003);
        for (int j = 0; j < 3; j++) begin
            v = 16'($urandom);
            wr(v);
            mwrite(6'h06, v);
        end
        rd("type2 ctl", 6'h06, model_reg[6], model_reg[6], 1);

        wreg(6'h00, 16'hBEEF);
        rd("crc write", 6'h00, model_reg[0], model_reg[0], 1);
        wreg(6'h05, 16'h0007);
        rd("rcrc", 6'h00, model_reg[0], model_reg[0], 1);

        wr(hdr(2'b10, 6'h0E, 5'd2));
        wr(16'h1234);
        wr(16'h5678);
        rd("stat id_err", 6'h08, stat_word(1'b1, 1'b1), 16'h0000, 1);

        wreg(6'h05, 16'h000D);
        wr(hdr(2'b01, 6'h08, 5'd1));
        bus.RDWRB = 1'b1;
        d_oe = 1'b0;
        #1;
        chk("desync header ignored", bus.BUSY, 0);
        tick();
        chk("desync still idle", bus.BUSY, 0);
        chk("desync keeps done", bus.DONE, 1);
        idle(1);
        wr(16'hAA99);
        wr(16'h5566);
        rd("resync stat", 6'h08, stat_word(1'b1, 1'b1), 16'h0000, 1);

        wr(hdr(2'b10, 6'h06, 5'd2));
        wr(16'h00FF);
        d_drv = brev(16'h0ABC);
        bus.PROGB = 1'b0;
        tick();
        chk("progb done", bus.DONE, 0);
        chk("progb busy", bus.BUSY, 1);
        foreach (model_reg[i])
            model_reg[i] = 16'h0000;
        bus.PROGB = 1'b1;
        idle(1);
        chk("progb release busy", bus.BUSY, 1);
        idle(1);
        chk("progb unsync busy", bus.BUSY, 0);
        wr(hdr(2'b01, 6'h08, 5'd1));
        bus.RDWRB = 1'b1;
        d_oe = 1'b0;
        #1;
        chk("cleared header ignored", bus.BUSY, 0);
        idle(1);
        run_tbl(1'b0);
        rd("ctl after clear", 6'h06, model_reg[6], model_reg[6], 1);
        rd("stat after clear", 6'h08, stat_word(1'b0, 1'b1), 16'h0000, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
